// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR pulse-sequence bitstream generator:
// command word field offsets, flag bit indices and the sequencer states.
package nmr_bstrm_pkg;

    // Bit offsets of the fields inside a 128-bit command word
    localparam int EDLY_LSB = 96;
    localparam int PLS_LSB  = 64;
    localparam int IDLY_LSB = 32;
    localparam int LOOP_LSB = 16;

    // Flag bit indices inside the low 16 bits of a command word
    localparam int FLG_LOOP_END   = 0;
    localparam int FLG_LOOP_START = 1;
    localparam int FLG_END        = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_IDLY   = 3'd3,
        ST_PLS    = 3'd4,
        ST_EDLY   = 3'd5,
        ST_NEXT   = 3'd6,
        ST_FIN    = 3'd7
    } state_t;

    // True for the two cycles in which the sequence RAM is being read
    function automatic logic is_fetch(input state_t s);
        return (s == ST_FETCH1) || (s == ST_FETCH2);
    endfunction

    // True for the three timed phases of a command
    function automatic logic is_timed(input state_t s);
        return (s == ST_IDLY) || (s == ST_PLS) || (s == ST_EDLY);
    endfunction

endpackage

// File: rtl/nmr_bstrm_timer.sv
// Loadable down-counter shared by the initial-delay, pulse and post-delay
// phases. A phase of length N is loaded with N and ends when the count is 1.
module nmr_bstrm_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expire,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt_r;

    // Load on phase entry, otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_WIDTH'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_WIDTH'(1'b1));
    assign zero   = (cnt_r == '0);

endmodule

// File: rtl/nmr_bstrm.sv
// SRAM-driven NMR pulse-sequence bitstream generator. Fetches 128-bit command
// words from address 0 upward and plays each as low/high/low phases on OUT,
// with one level of hardware looping and an end-of-program flag.
module nmr_bstrm
    import nmr_bstrm_pkg::*;
#(
    parameter int IDLY_WIDTH        = 32,
    parameter int PLS_WIDTH         = 32,
    parameter int EDLY_WIDTH        = 32,
    parameter int CNT_WIDTH         = 32,
    parameter int CMD_WIDTH         = 8,
    parameter int LOOP_WIDTH        = 16,
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    output logic                         DONE,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    output logic                         OUT
);

    state_t                       state_r, state_nxt_s;
    logic [SRAM_DAT_WIDTH-1:0]    cmd_r, word_s;
    logic [CMD_WIDTH-1:0]         ptr_r, ptr_nxt_s;
    logic [CMD_WIDTH-1:0]         loop_addr_r, loop_addr_nxt_s;
    logic [LOOP_WIDTH-1:0]        loop_n_r, loop_n_nxt_s;
    logic [LOOP_WIDTH-1:0]        iter_r, iter_nxt_s;
    logic [LOOP_WIDTH-1:0]        loop_field_s;
    logic                         loop_active_r, loop_active_nxt_s;
    logic                         done_r, done_nxt_s;
    logic                         out_r, cs_r;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_r;
    logic [CNT_WIDTH-1:0]         idly_s, pls_s, edly_s, tmr_val_s;
    logic                         tmr_load_s, tmr_expire_s, tmr_zero_s;
    logic                         unused_s;

    // The fetched word is only registered when FETCH2 ends, so the phase
    // decision leaving FETCH2 looks at the RAM data directly.
    assign word_s       = (state_r == ST_FETCH2) ? SRAM_RD_DAT : cmd_r;
    assign idly_s       = CNT_WIDTH'(word_s[IDLY_LSB +: IDLY_WIDTH]);
    assign pls_s        = CNT_WIDTH'(word_s[PLS_LSB  +: PLS_WIDTH]);
    assign edly_s       = CNT_WIDTH'(word_s[EDLY_LSB +: EDLY_WIDTH]);
    assign loop_field_s = cmd_r[LOOP_LSB +: LOOP_WIDTH];

    nmr_bstrm_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expire   (tmr_expire_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, pointer and loop bookkeeping
    always_comb begin
        state_nxt_s       = state_r;
        ptr_nxt_s         = ptr_r;
        loop_addr_nxt_s   = loop_addr_r;
        loop_n_nxt_s      = loop_n_r;
        iter_nxt_s        = iter_r;
        loop_active_nxt_s = loop_active_r;
        done_nxt_s        = done_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt_s       = ST_FETCH1;
                    ptr_nxt_s         = '0;
                    iter_nxt_s        = '0;
                    loop_active_nxt_s = 1'b0;
                    done_nxt_s        = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH1: state_nxt_s = ST_FETCH2;
            ST_FETCH2: begin
                if (idly_s != '0)      state_nxt_s = ST_IDLY;
                else if (pls_s != '0)  state_nxt_s = ST_PLS;
                else if (edly_s != '0) state_nxt_s = ST_EDLY;
                else                   state_nxt_s = ST_NEXT;
            end
            ST_IDLY: begin
                if (!tmr_expire_s)     state_nxt_s = ST_IDLY;
                else if (pls_s != '0)  state_nxt_s = ST_PLS;
                else if (edly_s != '0) state_nxt_s = ST_EDLY;
                else                   state_nxt_s = ST_NEXT;
            end
            ST_PLS: begin
                if (!tmr_expire_s)     state_nxt_s = ST_PLS;
                else if (edly_s != '0) state_nxt_s = ST_EDLY;
                else                   state_nxt_s = ST_NEXT;
            end
            ST_EDLY: begin
                if (tmr_expire_s) state_nxt_s = ST_NEXT;
                else              state_nxt_s = ST_EDLY;
            end
            ST_NEXT: begin
                if (cmd_r[FLG_END]) begin
                    state_nxt_s = ST_FIN;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_FETCH1;
                    if (cmd_r[FLG_LOOP_START] && !loop_active_r) begin
                        loop_addr_nxt_s   = ptr_r;
                        loop_n_nxt_s      = (loop_field_s == '0) ? LOOP_WIDTH'(1'b1) : loop_field_s;
                        iter_nxt_s        = LOOP_WIDTH'(1'b1);
                        loop_active_nxt_s = 1'b1;
                        ptr_nxt_s         = ptr_r + CMD_WIDTH'(1'b1);
                    end else if (cmd_r[FLG_LOOP_END] && loop_active_r) begin
                        if (iter_r < loop_n_r) begin
                            iter_nxt_s = iter_r + LOOP_WIDTH'(1'b1);
                            ptr_nxt_s  = loop_addr_r;
                        end else begin
                            loop_active_nxt_s = 1'b0;
                            ptr_nxt_s         = ptr_r + CMD_WIDTH'(1'b1);
                        end
                    end else begin
                        ptr_nxt_s = ptr_r + CMD_WIDTH'(1'b1);
                    end
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Timer load value for whichever timed phase is being entered
    always_comb begin
        tmr_val_s = '0;
        case (state_nxt_s)
            ST_IDLY: tmr_val_s = idly_s;
            ST_PLS:  tmr_val_s = pls_s;
            ST_EDLY: tmr_val_s = edly_s;
            default: tmr_val_s = '0;
        endcase
        tmr_load_s = (state_nxt_s != state_r) && is_timed(state_nxt_s);
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Pointer, loop state and captured command word
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r         <= '0;
            loop_addr_r   <= '0;
            loop_n_r      <= '0;
            iter_r        <= '0;
            loop_active_r <= 1'b0;
            cmd_r         <= '0;
        end else begin
            ptr_r         <= ptr_nxt_s;
            loop_addr_r   <= loop_addr_nxt_s;
            loop_n_r      <= loop_n_nxt_s;
            iter_r        <= iter_nxt_s;
            loop_active_r <= loop_active_nxt_s;
            if (state_r == ST_FETCH2) cmd_r <= SRAM_RD_DAT;
            else                      cmd_r <= cmd_r;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_r  <= 1'b0;
            cs_r   <= 1'b0;
            addr_r <= '0;
            done_r <= 1'b0;
        end else begin
            out_r  <= (state_nxt_s == ST_PLS);
            cs_r   <= is_fetch(state_nxt_s);
            addr_r <= SRAM_ADDR_WIDTH'(ptr_nxt_s);
            done_r <= done_nxt_s;
        end
    end

    assign OUT         = out_r;
    assign DONE        = done_r;
    assign SRAM_CS     = cs_r;
    assign SRAM_CLKEN  = cs_r;
    assign SRAM_ADDR   = addr_r;
    assign SRAM_WR     = 1'b0;
    assign SRAM_WR_DAT = '0;
    assign SRAM_BYTEEN = '1;

    // Flag bits and the timer idle indication carry no function here
    assign unused_s = ^{cmd_r, tmr_zero_s};

endmodule

// File: tb/tb_nmr_bstrm.sv
// Scoreboard bench for nmr_bstrm: a program interpreter pushes the expected
// fetch / pulse / done events; a monitor turns DUT activity into the same
// events and compares them.
module tb_nmr_bstrm;

    localparam int EV_FETCH = 0;
    localparam int EV_PULSE = 1;
    localparam int EV_DONE  = 2;
    localparam int F_LEND   = 1;
    localparam int F_LSTART = 2;
    localparam int F_END    = 4;

    typedef struct { int kind; int a; int b; } ev_t;

    logic          CLK, RST, START, DONE, SRAM_CS, SRAM_CLKEN, SRAM_WR, OUT;
    logic [7:0]    SRAM_ADDR;
    logic [127:0]  SRAM_RD_DAT, SRAM_WR_DAT;
    logic [15:0]   SRAM_BYTEEN;
    logic [127:0]  mem [0:255];

    ev_t exp_q[$];
    int  total = 0, bad = 0;
    int  ncyc = 0, anchor = 0, fstart = 0, ostart = 0;
    bit  running = 0, p_cs = 0, p_out = 0, p_done = 0;

    nmr_bstrm dut (
        .CLK(CLK), .RST(RST), .START(START), .DONE(DONE),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CS(SRAM_CS), .SRAM_CLKEN(SRAM_CLKEN),
        .SRAM_WR(SRAM_WR), .SRAM_RD_DAT(SRAM_RD_DAT), .SRAM_WR_DAT(SRAM_WR_DAT),
        .SRAM_BYTEEN(SRAM_BYTEEN), .OUT(OUT)
    );

    always #5 CLK = ~CLK;

    // Sequence RAM with one cycle of read latency
    always @(posedge CLK) if (SRAM_CS) SRAM_RD_DAT <= mem[SRAM_ADDR];

    function automatic logic [127:0] mk(input int i, input int p, input int e, input int n, input int f);
        logic [127:0] w;
        w = '0;
        w[63:32]  = i[31:0];
        w[95:64]  = p[31:0];
        w[127:96] = e[31:0];
        w[31:16]  = n[15:0];
        w[15:0]   = f[15:0];
        return w;
    endfunction

    function automatic string kname(input int k);
        if (k == EV_FETCH) return "fetch";
        else if (k == EV_PULSE) return "pulse";
        else return "done";
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) mem[k] = '0;
    endtask

    task automatic push_ev(input int k, input int a, input int b);
        ev_t ev;
        ev.kind = k; ev.a = a; ev.b = b;
        exp_q.push_back(ev);
    endtask

    task automatic check_ev(input int k, input int a, input int b);
        ev_t ev;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s got=(%0d,%0d) required=nothing at cycle %0d", kname(k), a, b, ncyc);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != k || ev.a != a || ev.b != b) begin
                bad++;
                $display("FAIL event got=%s(%0d,%0d) required=%s(%0d,%0d) at cycle %0d",
                         kname(k), a, b, kname(ev.kind), ev.a, ev.b, ncyc);
            end
        end
    endtask

    task automatic check1(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    // Interpret the program in mem the way the sequencer is meant to run it
    task automatic model_run(output int cycles);
        int ptr, lact, laddr, ln, it, gap, steps, i, p, e, n;
        bit fin;
        logic [127:0] w;
        ptr = 0; lact = 0; laddr = 0; ln = 0; it = 0; gap = 1; steps = 0; fin = 0;
        cycles = 0;
        while (!fin && steps < 1000) begin
            steps++;
            w = mem[ptr];
            i = int'(w[63:32]); p = int'(w[95:64]); e = int'(w[127:96]); n = int'(w[31:16]);
            push_ev(EV_FETCH, ptr, gap);
            if (p != 0) push_ev(EV_PULSE, 2 + i, p);
            gap = 3 + i + p + e;
            cycles += gap;
            if (w[2]) begin
                push_ev(EV_DONE, gap, 0);
                fin = 1;
            end else if (w[1] && lact == 0) begin
                lact = 1; laddr = ptr; ln = (n == 0) ? 1 : n; it = 1;
                ptr = (ptr + 1) % 256;
            end else if (w[0] && lact != 0) begin
                if (it < ln) begin it++; ptr = laddr; end
                else begin lact = 0; ptr = (ptr + 1) % 256; end
            end else begin
                ptr = (ptr + 1) % 256;
            end
        end
    endtask

    // Load-and-run: queue expectations, start, wait for the scoreboard to drain
    task automatic run_prog(input bit noisy);
        int cyc, lim;
        model_run(cyc);
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        check1("done_cleared_by_start", {127'd0, DONE}, 128'd0);
        lim = cyc + 40;
        for (int k = 0; k < lim; k++) begin
            @(posedge CLK); #1 START = 1'b0;
            if (exp_q.size() == 0) break;
            if (noisy) START = ($urandom_range(0, 5) == 0);
        end
        START = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL program_timeout got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge CLK);
        #1 check1("done_held_in_idle", {127'd0, DONE}, 128'd1);
    endtask

    // Monitor: convert DUT pin activity into events and score them
    always @(negedge CLK) begin
        ncyc++;
        total++;
        if (SRAM_WR !== 1'b0 || SRAM_BYTEEN !== 16'hFFFF || SRAM_WR_DAT !== 128'd0 || SRAM_CLKEN !== SRAM_CS) begin
            bad++;
            $display("FAIL tied_pins got wr=%b byteen=%h clken=%b cs=%b required wr=0 byteen=ffff clken=cs",
                     SRAM_WR, SRAM_BYTEEN, SRAM_CLKEN, SRAM_CS);
        end
        if (RST) begin
            exp_q.delete();
            running = 0; p_cs = 0; p_out = 0; p_done = 0;
        end else begin
            if (START && !running) begin
                anchor = ncyc;
                running = 1;
            end
            if (SRAM_CS && !p_cs) begin
                check_ev(EV_FETCH, int'(SRAM_ADDR), ncyc - anchor);
                anchor = ncyc;
                fstart = ncyc;
            end
            if (!SRAM_CS && p_cs) begin
                total++;
                if (ncyc - fstart != 2) begin
                    bad++;
                    $display("FAIL fetch_len got=%0d required=2", ncyc - fstart);
                end
            end
            if (OUT && !p_out) ostart = ncyc;
            if (!OUT && p_out) check_ev(EV_PULSE, ostart - anchor, ncyc - ostart);
            if (DONE && !p_done) begin
                check_ev(EV_DONE, ncyc - anchor, 0);
                running = 0;
            end
            p_cs = SRAM_CS; p_out = OUT; p_done = DONE;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fl, dummy;
        CLK = 1'b0; RST = 1'b1; START = 1'b0;
        clear_mem();
        repeat (3) @(posedge CLK);
        #1;
        check1("reset_out",   {127'd0, OUT},     128'd0);
        check1("reset_done",  {127'd0, DONE},    128'd0);
        check1("reset_cs",    {127'd0, SRAM_CS}, 128'd0);
        check1("reset_clken", {127'd0, SRAM_CLKEN}, 128'd0);
        check1("reset_addr",  {120'd0, SRAM_ADDR}, 128'd0);
        RST = 1'b0;

        // Single command
        clear_mem();
        mem[0] = mk(5, 5, 5, 4, F_END);
        run_prog(0);

        // Loop program, N=4
        clear_mem();
        mem[0] = mk(5, 5, 5, 4, 0);
        mem[1] = mk(5, 8, 5, 4, F_LSTART);
        mem[2] = mk(5, 8, 5, 4, F_LEND);
        mem[3] = mk(10, 10, 10, 4, F_END);
        run_prog(0);

        // Same program with START pulses during execution
        run_prog(1);

        // Zero fields
        clear_mem();
        mem[0] = mk(0, 3, 0, 0, F_END);
        run_prog(0);
        clear_mem();
        mem[0] = mk(5, 0, 5, 0, F_END);
        run_prog(0);
        clear_mem();
        mem[0] = mk(0, 0, 0, 0, 0);
        mem[1] = mk(1, 1, 1, 0, F_END);
        run_prog(0);

        // LOOP_START with N=0 runs the body once; stray LOOP_END is plain
        clear_mem();
        mem[0] = mk(1, 2, 1, 0, F_LEND);
        mem[1] = mk(1, 2, 1, 0, F_LSTART);
        mem[2] = mk(1, 3, 1, 0, F_LEND);
        mem[3] = mk(1, 1, 1, 0, F_END);
        run_prog(0);

        // Reset in the middle of a pulse
        clear_mem();
        mem[0] = mk(3, 20, 3, 0, F_END);
        model_run(dummy);
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK); #1;
            if (OUT) break;
        end
        check1("pulse_before_reset", {127'd0, OUT}, 128'd1);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        check1("rst_mid_out",  {127'd0, OUT},     128'd0);
        check1("rst_mid_cs",   {127'd0, SRAM_CS}, 128'd0);
        check1("rst_mid_done", {127'd0, DONE},    128'd0);
        repeat (3) @(posedge CLK);
        #1;
        check1("rst_idle_out", {127'd0, OUT},     128'd0);
        check1("rst_idle_cs",  {127'd0, SRAM_CS}, 128'd0);
        clear_mem();
        mem[0] = mk(2, 4, 2, 0, 0);
        mem[1] = mk(1, 1, 1, 0, F_END);
        run_prog(0);

        // Randomised programs
        for (int t = 0; t < 20; t++) begin
            clear_mem();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                fl = $urandom_range(0, 5);
                if (fl == 3)      fl = F_LSTART;
                else if (fl == 4) fl = F_LEND;
                else              fl = 0;
                if (k == n - 1) fl = F_END;
                fl = fl | int'($urandom_range(0, 8191) << 3);
                mem[k] = mk($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                            $urandom_range(0, 3), fl);
            end
            run_prog(t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
